prv32_mdu_seq: RTL and testbench

PRV32_MDU_SEQ -- requirements
Module: prv32_mdu_seq

---
 rtl/prv32_mdu_seq.sv | 128 ++++++++++++
 tb/tb_prv32_mdu_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/prv32_mdu_seq.sv
// Sequential 32-bit multiply/divide unit: MUL, MULHU, DIVU, REMU, one bit per cycle on a shared external ALU.
// Latency: done pulses 32 cycles after the edge that samples start. Busy covers the RUN and DONE states.
// Backpressure: start is only honoured in IDLE. A start seen while busy is dropped and leaves all state unchanged.
module prv32_mdu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        alu_req,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_fn,
    input  logic [31:0] alu_r,
    input  logic        alu_cf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [3:0] FN_ADD   = 4'b0000;
    localparam logic [3:0] FN_SUB   = 4'b0001;

    state_t      state;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    // Multiplicand for MUL/MULHU, divisor for DIVU/REMU.
    logic [31:0] opnd;
    // hi: product high word or partial remainder R.
    // lo: multiplier shift register or quotient/dividend Q.
    logic [31:0] hi;
    logic [31:0] lo;

    logic        is_div;
    logic        ok;
    logic [31:0] hi_n;
    logic [31:0] lo_n;

    assign is_div  = op_q[1];
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign alu_req = (state == S_RUN);

    // Drive the shared ALU for the current iteration. All ALU inputs stay zero outside RUN.
    always_comb begin
        alu_a  = 32'd0;
        alu_b  = 32'd0;
        alu_fn = FN_ADD;
        if (state == S_RUN) begin
            if (is_div) begin
                alu_a  = {hi[30:0], lo[31]};
                alu_b  = opnd;
                alu_fn = FN_SUB;
            end else begin
                alu_a  = hi;
                alu_b  = lo[0] ? opnd : 32'd0;
                alu_fn = FN_ADD;
            end
        end
    end

    // Next accumulator values from the ALU result.
    // In divide mode, R[31] set means the shifted remainder is already at least 2^32 > divisor,
    // so the subtract is taken regardless of borrow.
    always_comb begin
        ok   = hi[31] | alu_cf;
        hi_n = hi;
        lo_n = lo;
        if (is_div) begin
            hi_n = ok ? alu_r : alu_a;
            lo_n = {lo[30:0], ok};
        end else begin
            hi_n = {alu_cf, alu_r[31:1]};
            lo_n = {alu_r[0], lo[31:1]};
        end
    end

    // Control FSM and datapath registers. The result is captured on the final iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 5'd0;
            op_q   <= OP_MUL;
            opnd   <= 32'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            result <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        opnd  <= op[1] ? rs2 : rs1;
                        lo    <= op[1] ? rs1 : rs2;
                        hi    <= 32'd0;
                        cnt   <= 5'd0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        // MULHU and REMU take the high register, MUL and DIVU take the low register.
                        result <= op_q[0] ? hi_n : lo_n;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prv32_mdu_seq.sv
// Testbench for prv32_mdu_seq. It models the shared ALU and checks results against plain-arithmetic expectations.
// Latency: each operation is expected to take 32 cycles from accepted start to done.
// Backpressure: covers a start ignored while busy, a restart right after done, and a reset abort.
module tb_prv32_mdu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        alu_req;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_fn;
    logic [31:0] alu_r;
    logic        alu_cf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prv32_mdu_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs1     (rs1),
        .rs2     (rs2),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .alu_req (alu_req),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_fn  (alu_fn),
        .alu_r   (alu_r),
        .alu_cf  (alu_cf)
    );

    // Combinational shared ALU: add, or subtract where carry out means no borrow.
    always_comb begin
        logic [32:0] s;
        if (alu_fn == 4'b0001) s = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        else                   s = {1'b0, alu_a} + {1'b0, alu_b};
        alu_r  = s[31:0];
        alu_cf = s[32];
    end

    // Reference result from plain arithmetic.
    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (o)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Present one start pulse. The next rising edge samples it.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen. The wait is bounded.
    task automatic wait_done(output int n, output bit timeout);
        n = 0;
        timeout = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; rs1 = 32'd0; rs2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
        n_cmp++; if (alu_req !== 1'b0)  begin n_bad++; $display("FAIL reset_alu_req got=%b want=0", alu_req); end
        n_cmp++; if (result !== 32'd0)  begin n_bad++; $display("FAIL reset_result got=%h want=0", result); end
        n_cmp++; if ({alu_a, alu_b, alu_fn} !== 68'd0)
            begin n_bad++; $display("FAIL reset_alu_bus got=%h/%h/%h want=0", alu_a, alu_b, alu_fn); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [8] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3};
        logic [31:0] t_a  [8] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd100, 32'h80000000, 32'd5, 32'd5};
        logic [31:0] t_b  [8] = '{32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7, 32'd1, 32'd0, 32'd0};
        logic [31:0] t_e  [8] = '{32'd42, 32'hFFFFFFFE, 32'd1, 32'd14, 32'd2, 32'h80000000, 32'hFFFFFFFF, 32'd5};
        for (int k = 0; k < 8; k++) begin
            int  n;
            bit  to;
            bit  run_bad;
            issue(t_op[k], t_a[k], t_b[k]);
            n = 0; to = 1'b1; run_bad = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (!done && (busy !== 1'b1 || alu_req !== 1'b1)) run_bad = 1'b1;
                @(posedge clk); #1;
                n++;
                if (done) begin to = 1'b0; break; end
            end
            n_cmp++; if (to || n != 32)
                begin n_bad++; $display("FAIL dir%0d_latency got=%0d timeout=%0b want=32", k, n, to); end
            n_cmp++; if (run_bad)
                begin n_bad++; $display("FAIL dir%0d_busy_during_run got=low want=high", k); end
            n_cmp++; if (result !== t_e[k])
                begin n_bad++; $display("FAIL dir%0d_result got=%h want=%h", k, result, t_e[k]); end
            n_cmp++; if (busy !== 1'b1 || alu_req !== 1'b0 || {alu_a, alu_b, alu_fn} !== 68'd0)
                begin n_bad++; $display("FAIL dir%0d_done_state busy=%b alu_req=%b alu=%h/%h/%h want=1/0/0", k, busy, alu_req, alu_a, alu_b, alu_fn); end
            @(posedge clk); #1;
            n_cmp++; if (done !== 1'b0 || busy !== 1'b0)
                begin n_bad++; $display("FAIL dir%0d_after_done done=%b busy=%b want=0/0", k, done, busy); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            logic [1:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] e;
            int n;
            bit to;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(0, 15));
                2: b = 32'd0;
                default: b = $urandom | 32'h8000_0000;
            endcase
            e = ref_model(o, a, b);
            issue(o, a, b);
            wait_done(n, to);
            n_cmp++; if (to || n != 32 || result !== e)
                begin n_bad++; $display("FAIL rand%0d op=%0d a=%h b=%h got=%h lat=%0d want=%h lat=32", k, o, a, b, result, n, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_start_ignored();
        int n;
        bit to;
        issue(2'b00, 32'd1234, 32'd5678);
        repeat (9) @(posedge clk);
        #1;
        op = 2'b11; rs1 = 32'd999; rs2 = 32'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n, to);
        n_cmp++; if (to || 10 + n != 32)
            begin n_bad++; $display("FAIL ignored_start_latency got=%0d want=32", 10 + n); end
        n_cmp++; if (result !== 32'd7006652)
            begin n_bad++; $display("FAIL ignored_start_result got=%h want=%h", result, 32'd7006652); end
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0)
            begin n_bad++; $display("FAIL ignored_start_no_rerun busy=%b want=0", busy); end
    endtask

    task automatic test_back_to_back();
        int n;
        bit to;
        logic [31:0] prev;
        issue(2'b10, 32'd1000, 32'd9);
        wait_done(n, to);
        prev = result;
        n_cmp++; if (to || prev !== 32'd111)
            begin n_bad++; $display("FAIL b2b_first got=%h want=%h", prev, 32'd111); end
        // Start is held through the done cycle. It must only take effect one cycle later.
        op = 2'b11; rs1 = 32'd1000; rs2 = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0)
            begin n_bad++; $display("FAIL b2b_accept_in_done busy=%b want=0", busy); end
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || result !== prev)
            begin n_bad++; $display("FAIL b2b_accept busy=%b result=%h want=1/%h", busy, result, prev); end
        wait_done(n, to);
        n_cmp++; if (to || n + 2 != 34 || result !== 32'd1)
            begin n_bad++; $display("FAIL b2b_second lat=%0d result=%h want=34/1", n + 2, result); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int n;
        bit to;
        bit saw_done;
        issue(2'b00, 32'd77, 32'd88);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || alu_req !== 1'b0 || result !== 32'd0)
            begin n_bad++; $display("FAIL abort_state busy=%b done=%b req=%b result=%h want=0/0/0/0", busy, done, alu_req, result); end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        n_cmp++; if (saw_done)
            begin n_bad++; $display("FAIL abort_no_done got=activity want=idle"); end
        issue(2'b00, 32'd3, 32'd3);
        wait_done(n, to);
        n_cmp++; if (to || n != 32 || result !== 32'd9)
            begin n_bad++; $display("FAIL abort_then_mul lat=%0d result=%h want=32/9", n, result); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
